// File: rtl/orv64_pmp_checker_pkg.sv
// Shared parameters and CSR/request types for the ORV64 PMP checker slice.
package orv64_param_pkg;

    localparam int ORV64_N_PMP_CSR       = 16;
    localparam int ORV64_PHY_ADDR_WIDTH  = 56;

endpackage

package orv64_typedef_pkg;

    import orv64_param_pkg::*;

    typedef enum logic [1:0] {
        ORV64_PMP_OFF   = 2'd0,
        ORV64_PMP_TOR   = 2'd1,
        ORV64_PMP_NA4   = 2'd2,
        ORV64_PMP_NAPOT = 2'd3
    } orv64_pmp_a_t;

    typedef enum logic [1:0] {
        ORV64_PMP_ACC_READ  = 2'd0,
        ORV64_PMP_ACC_WRITE = 2'd1,
        ORV64_PMP_ACC_EXEC  = 2'd2
    } orv64_pmp_acc_t;

    typedef enum logic [1:0] {
        ORV64_PMP_ST_IDLE = 2'd0,
        ORV64_PMP_ST_SCAN = 2'd1,
        ORV64_PMP_ST_RESP = 2'd2
    } orv64_pmp_state_t;

    // Architectural pmpcfg byte layout: L, reserved, A, X, W, R (MSB to LSB).
    typedef struct packed {
        logic         l;
        logic [1:0]   rsvd;
        orv64_pmp_a_t a;
        logic         x;
        logic         w;
        logic         r;
    } orv64_csr_pmpcfg_t;

    typedef logic [ORV64_PHY_ADDR_WIDTH-3:0] orv64_csr_pmpaddr_t;

    localparam logic [1:0] ORV64_PRV_M = 2'd3;

endpackage

// File: rtl/orv64_napot_addr.sv
// Decodes a NAPOT-encoded pmpaddr into its inclusive byte-address window.
module orv64_napot_addr
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;
(
    input  orv64_csr_pmpaddr_t                pmpaddr,
    output logic [ORV64_PHY_ADDR_WIDTH-1:0]   napot_base,
    output logic [ORV64_PHY_ADDR_WIDTH-1:0]   napot_bounds
);

    // Trailing ones of pmpaddr plus the first zero above them mark the size field.
    orv64_csr_pmpaddr_t size_mask_s;

    assign size_mask_s  = pmpaddr ^ (pmpaddr + orv64_csr_pmpaddr_t'(1'b1));
    assign napot_base   = {pmpaddr & ~size_mask_s, 2'b00};
    assign napot_bounds = {pmpaddr | size_mask_s, 2'b11};

endmodule

// File: rtl/orv64_pmp_checker.sv
// Sequential PMP checker: scans one entry per cycle, lowest index wins.
module orv64_pmp_checker
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;
#(
    parameter int N_PMP = ORV64_N_PMP_CSR
)(
    input  logic                                  clk,
    input  logic                                  rstn,
    input  orv64_csr_pmpcfg_t  [N_PMP-1:0]        pmpcfg,
    input  orv64_csr_pmpaddr_t [N_PMP-1:0]        pmpaddr,
    input  logic                                  csr_update,
    input  logic                                  flush,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [ORV64_PHY_ADDR_WIDTH-1:0]       req_paddr,
    input  logic [1:0]                            req_size,
    input  orv64_pmp_acc_t                        req_acc,
    input  logic [1:0]                            req_prv,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output logic                                  resp_allow,
    output logic                                  resp_hit,
    output logic [$clog2(N_PMP)-1:0]              resp_idx
);

    localparam int AW    = ORV64_PHY_ADDR_WIDTH;
    localparam int IDX_W = $clog2(N_PMP);

    orv64_pmp_state_t    state_r, state_nx_s;
    logic [IDX_W-1:0]    cnt_r, cnt_nx_s;
    logic [AW-1:0]       start_r, end_r;
    logic                wrap_r;
    orv64_pmp_acc_t      acc_r;
    logic [1:0]          prv_r;
    logic                req_ready_r, resp_valid_r, resp_allow_r, resp_hit_r;
    logic [IDX_W-1:0]    resp_idx_r;

    logic                accept_s;
    logic [2:0]          len_m1_s;
    logic [AW:0]         end_sum_s;
    orv64_csr_pmpcfg_t   cfg_s;
    orv64_csr_pmpaddr_t  addr_s, prev_addr_s;
    logic [AW-1:0]       tor_lo_s, tor_hi_s, napot_base_s, napot_bounds_s;
    logic                start_in_s, end_in_s, full_s, partial_s, perm_s;
    logic                last_s, decide_s, allow_dec_s, hit_dec_s;

    assign accept_s    = (state_r == ORV64_PMP_ST_IDLE) && req_valid && !flush;
    assign cfg_s       = pmpcfg[cnt_r];
    assign addr_s      = pmpaddr[cnt_r];
    assign prev_addr_s = (cnt_r == {IDX_W{1'b0}}) ? '0 : pmpaddr[cnt_r - IDX_W'(1)];
    assign tor_lo_s    = {prev_addr_s, 2'b00};
    assign tor_hi_s    = {addr_s, 2'b00};
    assign last_s      = (cnt_r == IDX_W'(N_PMP - 1));

    orv64_napot_addr u_napot_addr (
        .pmpaddr      (addr_s),
        .napot_base   (napot_base_s),
        .napot_bounds (napot_bounds_s)
    );

    // Byte count minus one; a carry out of the address width flags a wrapping access.
    always_comb begin
        case (req_size)
            2'd0:    len_m1_s = 3'd0;
            2'd1:    len_m1_s = 3'd1;
            2'd2:    len_m1_s = 3'd3;
            2'd3:    len_m1_s = 3'd7;
            default: len_m1_s = 3'd0;
        endcase
        end_sum_s = {1'b0, req_paddr} + (AW+1)'(len_m1_s);
    end

    // Range membership of the captured start/end for the entry being scanned.
    always_comb begin
        start_in_s = 1'b0;
        end_in_s   = 1'b0;
        case (cfg_s.a)
            ORV64_PMP_TOR: begin
                if (tor_lo_s < tor_hi_s) begin
                    start_in_s = (start_r >= tor_lo_s) && (start_r < tor_hi_s);
                    end_in_s   = (end_r >= tor_lo_s) && (end_r < tor_hi_s);
                end else begin
                    start_in_s = 1'b0;
                    end_in_s   = 1'b0;
                end
            end
            ORV64_PMP_NA4: begin
                start_in_s = (start_r[AW-1:2] == addr_s);
                end_in_s   = (end_r[AW-1:2] == addr_s);
            end
            ORV64_PMP_NAPOT: begin
                start_in_s = (start_r >= napot_base_s) && (start_r <= napot_bounds_s);
                end_in_s   = (end_r >= napot_base_s) && (end_r <= napot_bounds_s);
            end
            default: begin
                start_in_s = 1'b0;
                end_in_s   = 1'b0;
            end
        endcase
    end

    // Permission bit selected by access type.
    always_comb begin
        case (acc_r)
            ORV64_PMP_ACC_READ:  perm_s = cfg_s.r;
            ORV64_PMP_ACC_WRITE: perm_s = cfg_s.w;
            ORV64_PMP_ACC_EXEC:  perm_s = cfg_s.x;
            default:             perm_s = 1'b0;
        endcase
    end

    // Decision for the current entry; a wrapping access is denied without a hit.
    always_comb begin
        full_s      = start_in_s & end_in_s;
        partial_s   = start_in_s ^ end_in_s;
        decide_s    = wrap_r | full_s | partial_s | last_s;
        allow_dec_s = 1'b0;
        hit_dec_s   = 1'b0;
        if (wrap_r) begin
            allow_dec_s = 1'b0;
            hit_dec_s   = 1'b0;
        end else if (full_s) begin
            allow_dec_s = ((prv_r == ORV64_PRV_M) && !cfg_s.l) || perm_s;
            hit_dec_s   = 1'b1;
        end else if (partial_s) begin
            allow_dec_s = 1'b0;
            hit_dec_s   = 1'b1;
        end else begin
            allow_dec_s = (prv_r == ORV64_PRV_M);
            hit_dec_s   = 1'b0;
        end
    end

    // Next-state logic: flush beats csr_update, csr_update beats a decision.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ORV64_PMP_ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ORV64_PMP_ST_SCAN;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ORV64_PMP_ST_IDLE;
                end
            end
            ORV64_PMP_ST_SCAN: begin
                if (flush) begin
                    state_nx_s = ORV64_PMP_ST_IDLE;
                end else if (csr_update) begin
                    cnt_nx_s   = '0;
                end else if (decide_s) begin
                    state_nx_s = ORV64_PMP_ST_RESP;
                end else begin
                    cnt_nx_s   = cnt_r + IDX_W'(1);
                end
            end
            ORV64_PMP_ST_RESP: begin
                if (flush || resp_ready) begin
                    state_nx_s = ORV64_PMP_ST_IDLE;
                end else begin
                    state_nx_s = ORV64_PMP_ST_RESP;
                end
            end
            default: state_nx_s = ORV64_PMP_ST_IDLE;
        endcase
    end

    // State, counter and handshake flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ORV64_PMP_ST_IDLE;
            cnt_r        <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            req_ready_r  <= (state_nx_s == ORV64_PMP_ST_IDLE);
            resp_valid_r <= (state_nx_s == ORV64_PMP_ST_RESP);
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_r <= '0;
            end_r   <= '0;
            wrap_r  <= 1'b0;
            acc_r   <= ORV64_PMP_ACC_READ;
            prv_r   <= 2'd0;
        end else if (accept_s) begin
            start_r <= req_paddr;
            end_r   <= end_sum_s[AW-1:0];
            wrap_r  <= end_sum_s[AW];
            acc_r   <= req_acc;
            prv_r   <= req_prv;
        end
    end

    // Response payload, loaded only when the scan actually concludes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_allow_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_idx_r   <= '0;
        end else if ((state_r == ORV64_PMP_ST_SCAN) && !flush && !csr_update && decide_s) begin
            resp_allow_r <= allow_dec_s;
            resp_hit_r   <= hit_dec_s;
            resp_idx_r   <= hit_dec_s ? cnt_r : '0;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_allow = resp_allow_r;
    assign resp_hit   = resp_hit_r;
    assign resp_idx   = resp_idx_r;

endmodule

// File: tb/tb_orv64_pmp_checker.sv
// Directed scoreboard bench for orv64_pmp_checker.
module tb_orv64_pmp_checker;

    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;

    localparam int NP = 16;

    typedef struct {
        logic       allow;
        logic       hit;
        logic [3:0] idx;
        int         lat;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rstn;
    orv64_csr_pmpcfg_t  [NP-1:0] pmpcfg;
    orv64_csr_pmpaddr_t [NP-1:0] pmpaddr;
    logic                        csr_update, flush, req_valid, req_ready;
    logic [55:0]                 req_paddr;
    logic [1:0]                  req_size, req_prv;
    orv64_pmp_acc_t              req_acc;
    logic                        resp_valid, resp_ready, resp_allow, resp_hit;
    logic [3:0]                  resp_idx;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    orv64_pmp_checker #(.N_PMP(NP)) dut (
        .clk(clk), .rstn(rstn), .pmpcfg(pmpcfg), .pmpaddr(pmpaddr),
        .csr_update(csr_update), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_paddr(req_paddr), .req_size(req_size), .req_acc(req_acc), .req_prv(req_prv),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_allow(resp_allow), .resp_hit(resp_hit), .resp_idx(resp_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_csrs();
        for (int i = 0; i < NP; i++) begin
            pmpcfg[i]  = '0;
            pmpaddr[i] = '0;
        end
    endtask

    task automatic drive_req(input logic [55:0] pa, input logic [1:0] sz,
                             input orv64_pmp_acc_t acc, input logic [1:0] prv);
        req_paddr = pa;
        req_size  = sz;
        req_acc   = acc;
        req_prv   = prv;
        req_valid = 1'b1;
    endtask

    // Waits (bounded) for resp_valid, then compares against the head of the scoreboard.
    task automatic wait_and_compare(input string tag, inout int lat);
        exp_t e;
        while (resp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".valid"}, 64'(resp_valid), 64'd1);
        e = sb_q.pop_front();
        check({tag, ".allow"}, 64'(resp_allow), 64'(e.allow));
        check({tag, ".hit"},   64'(resp_hit),   64'(e.hit));
        check({tag, ".idx"},   64'(resp_idx),   64'(e.idx));
        if (e.lat != 0) check({tag, ".latency"}, 64'(lat), 64'(e.lat));
    endtask

    task automatic run_req(input string tag, input logic [55:0] pa, input logic [1:0] sz,
                           input orv64_pmp_acc_t acc, input logic [1:0] prv,
                           input logic allow, input logic hit, input logic [3:0] idx,
                           input int lat_exp);
        exp_t e;
        int   lat;
        logic [6:0] held;
        e.allow = allow; e.hit = hit; e.idx = idx; e.lat = lat_exp;
        sb_q.push_back(e);
        drive_req(pa, sz, acc, prv);
        tick();
        req_valid = 1'b0;
        lat = 1;
        wait_and_compare(tag, lat);
        held = {resp_valid, resp_allow, resp_hit, resp_idx};
        tick();
        check({tag, ".hold"}, 64'({resp_valid, resp_allow, resp_hit, resp_idx}), 64'({1'b1, allow, hit, idx}));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, ".ready_after"}, 64'({req_ready, resp_valid}), 64'b10);
        if (held[6] !== 1'b1) check({tag, ".held_valid"}, 64'(held[6]), 64'd1);
    endtask

    initial begin
        int   lat;
        logic seen_valid;
        logic [55:0] all_ones;
        exp_t e;
        all_ones   = '1;
        rstn       = 1'b0;
        csr_update = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_paddr  = '0;
        req_size   = 2'd0;
        req_acc    = ORV64_PMP_ACC_READ;
        req_prv    = 2'd0;
        clear_csrs();
        tick(); tick();
        check("reset.outputs", 64'({resp_valid, resp_allow, resp_hit, resp_idx}), 64'd0);
        rstn = 1'b1;
        tick();
        check("reset.req_ready", 64'(req_ready), 64'd1);

        // 8 KiB NAPOT region at 0x8000_0000 in entry 0.
        pmpcfg[0].a = ORV64_PMP_NAPOT;
        pmpcfg[0].r = 1'b1;
        pmpaddr[0]  = 54'h2000_03FF;
        run_req("napot_read_u",  56'h8000_1000, 2'd3, ORV64_PMP_ACC_READ,  2'd0, 1'b1, 1'b1, 4'd0, 2);
        run_req("napot_write_u", 56'h8000_1000, 2'd3, ORV64_PMP_ACC_WRITE, 2'd0, 1'b0, 1'b1, 4'd0, 2);
        run_req("napot_write_m", 56'h8000_1000, 2'd3, ORV64_PMP_ACC_WRITE, 2'd3, 1'b1, 1'b1, 4'd0, 2);
        pmpcfg[0].l = 1'b1;
        run_req("napot_write_ml", 56'h8000_1000, 2'd3, ORV64_PMP_ACC_WRITE, 2'd3, 1'b0, 1'b1, 4'd0, 2);
        run_req("napot_top_byte", 56'h8000_1FFF, 2'd0, ORV64_PMP_ACC_READ,  2'd0, 1'b1, 1'b1, 4'd0, 2);
        pmpcfg[0].l = 1'b0;
        run_req("wrap_m", all_ones, 2'd3, ORV64_PMP_ACC_READ, 2'd3, 1'b0, 1'b0, 4'd0, 0);

        // TOR [0x1000,0x2000) in entry 2 (lower bound from entry 1), NA4 0x1FFC in entry 5.
        clear_csrs();
        pmpaddr[1]  = 54'h400;
        pmpcfg[2].a = ORV64_PMP_TOR;
        pmpcfg[2].x = 1'b1;
        pmpaddr[2]  = 54'h800;
        pmpcfg[5].a = ORV64_PMP_NA4;
        pmpcfg[5].r = 1'b1;
        pmpaddr[5]  = 54'h7FF;
        run_req("tor_exec",     56'h1FFC, 2'd2, ORV64_PMP_ACC_EXEC, 2'd0, 1'b1, 1'b1, 4'd2, 4);
        run_req("tor_read_lowest_wins", 56'h1FFC, 2'd2, ORV64_PMP_ACC_READ, 2'd0, 1'b0, 1'b1, 4'd2, 4);
        run_req("tor_partial",  56'h1FFE, 2'd2, ORV64_PMP_ACC_READ, 2'd0, 1'b0, 1'b1, 4'd2, 4);
        run_req("tor_upper_excl", 56'h2000, 2'd2, ORV64_PMP_ACC_EXEC, 2'd1, 1'b0, 1'b0, 4'd0, NP + 1);
        run_req("tor_lower_incl", 56'h1000, 2'd0, ORV64_PMP_ACC_EXEC, 2'd0, 1'b1, 1'b1, 4'd2, 4);

        // Nothing enabled.
        clear_csrs();
        run_req("off_s", 56'h8000_1000, 2'd3, ORV64_PMP_ACC_READ, 2'd1, 1'b0, 1'b0, 4'd0, NP + 1);
        run_req("off_m", 56'h8000_1000, 2'd3, ORV64_PMP_ACC_READ, 2'd3, 1'b1, 1'b0, 4'd0, NP + 1);

        // Flush while idle must block acceptance.
        drive_req(56'h1000, 2'd0, ORV64_PMP_ACC_READ, 2'd3);
        flush = 1'b1;
        tick();
        check("flush_idle.ready", 64'(req_ready), 64'd1);
        flush     = 1'b0;
        req_valid = 1'b0;
        tick();

        // csr_update at scan index 3 restarts from entry 0 with the newly written entry.
        e.allow = 1'b1; e.hit = 1'b1; e.idx = 4'd0; e.lat = 6;
        sb_q.push_back(e);
        drive_req(56'h8000_1000, 2'd3, ORV64_PMP_ACC_READ, 2'd1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        tick(); lat++;
        tick(); lat++;
        tick(); lat++;
        csr_update  = 1'b1;
        pmpcfg[0].a = ORV64_PMP_NAPOT;
        pmpcfg[0].r = 1'b1;
        pmpaddr[0]  = 54'h2000_03FF;
        tick(); lat++;
        csr_update = 1'b0;
        wait_and_compare("csr_restart", lat);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_resp.idle", 64'({req_ready, resp_valid}), 64'b10);
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_valid = seen_valid | resp_valid;
        end
        check("flush_resp.no_pulse", 64'(seen_valid), 64'd0);

        // Flush mid-scan: no response ever appears.
        clear_csrs();
        drive_req(56'h40, 2'd0, ORV64_PMP_ACC_READ, 2'd3);
        tick();
        req_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < NP + 4; i++) begin
            tick();
            seen_valid = seen_valid | resp_valid;
        end
        check("flush_scan.no_resp", 64'({seen_valid, req_ready}), 64'b01);

        // Reset mid-scan discards the request.
        drive_req(56'h40, 2'd0, ORV64_PMP_ACC_READ, 2'd3);
        tick();
        req_valid = 1'b0;
        tick(); tick();
        rstn = 1'b0;
        #1;
        check("reset_mid.async", 64'({resp_valid, req_ready}), 64'b01);
        tick();
        rstn = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < NP + 4; i++) begin
            tick();
            seen_valid = seen_valid | resp_valid;
        end
        check("reset_mid.no_resp", 64'({seen_valid, req_ready}), 64'b01);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/orv64_pmp_checker.md
ORV64_PMP_CHECKER -- requirements
Module: orv64_pmp_checker

Interface
REQ-001 Parameter N_PMP, default ORV64_N_PMP_CSR (16): number of PMP entries scanned.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 pmpcfg  input  N_PMP x orv64_csr_pmpcfg_t  per-entry R, W, X, A[1:0], L.
REQ-005 pmpaddr  input  N_PMP x orv64_csr_pmpaddr_t  per-entry address CSR, PA[top:2].
REQ-006 csr_update  input  1  pulse: a pmpcfg/pmpaddr write committed this cycle.
REQ-007 flush  input  1  abort any in-flight check.
REQ-008 req_valid / req_ready  input / output  1 / 1  request handshake.
REQ-009 req_paddr  input  ORV64_PHY_ADDR_WIDTH  access start address.
REQ-010 req_size  input  2  access bytes = 1 << req_size (1, 2, 4, 8).
REQ-011 req_acc  input  orv64_pmp_acc_t  READ, WRITE or EXEC.
REQ-012 req_prv  input  2  privilege: U=0, S=1, M=3.
REQ-013 resp_valid / resp_ready  output / input  1 / 1  response handshake.
REQ-014 resp_allow  output  1  1 = access permitted, 0 = access fault.
REQ-015 resp_hit  output  1  an entry matched.
REQ-016 resp_idx  output  $clog2(N_PMP)  index of matching entry; 0 when resp_hit=0.

Function
REQ-017 FSM states IDLE, SCAN, RESP; req_ready = (state==IDLE).
REQ-018 IDLE: req_valid&req_ready registers paddr, end address (paddr + bytes - 1), acc, prv; entry counter <= 0; next state SCAN.
REQ-019 SCAN: one entry per cycle, index ascending; lowest-numbered matching entry wins; scan stops at first full or partial match.
REQ-020 A=OFF never matches; NA4 matches iff addr[top:2]==pmpaddr; NAPOT range [napot_base, napot_bounds] inclusive; TOR range [pmpaddr[i-1]<<2, pmpaddr[i]<<2), lower bound 0 for entry 0; TOR with lower >= upper never matches.
REQ-021 Full match: start and end both in range; partial match (exactly one in range): resp_hit=1, resp_allow=0.
REQ-022 Full match permission: prv==M and L==0 -> allow; otherwise allow iff R, W or X bit for req_acc is set.
REQ-023 No entry matched after index N_PMP-1: resp_hit=0, resp_allow = (prv==M).
REQ-024 End address carry-out beyond ORV64_PHY_ADDR_WIDTH (wrap) -> treated as partial match on no entry: resp_allow=0, resp_hit=0.
REQ-025 Decision registered; RESP asserts resp_valid the cycle after deciding entry evaluated; latency accept-to-resp_valid = k+2 cycles, k = deciding index (min 2, max N_PMP+1).
REQ-026 RESP: resp_* held stable until resp_valid&resp_ready, then IDLE; no new request accepted in the same cycle.
REQ-027 csr_update in SCAN restarts scan at entry 0 next cycle with captured request; ignored in IDLE and RESP.
REQ-028 flush in SCAN or RESP -> IDLE next cycle, no response; flush wins over csr_update and resp_ready; flush in IDLE blocks acceptance that cycle.
REQ-029 CSR inputs sampled live each SCAN cycle; no internal copy.

Reset
REQ-030 rstn low asynchronously forces IDLE; resp_valid, resp_allow, resp_hit, resp_idx = 0; req_ready = 1 after deassertion.
REQ-031 Reset mid-SCAN or mid-RESP discards the request; no response emitted.

Structure
REQ-032 orv64_pmp_acc_t, orv64_pmp_a_t (OFF, TOR, NA4, NAPOT), ORV64_N_PMP_CSR reside in orv64_param_pkg / orv64_typedef_pkg.
REQ-033 One sub-module: orv64_napot_addr instantiated once, fed pmpaddr[counter], yielding napot_base/napot_bounds for the current entry.
REQ-034 Range comparators and permission logic inline; no further sub-modules.

Verification
REQ-035 Entry 0 NAPOT pmpaddr=0x2000_03FF (8 KiB at 0x8000_0000), R=1, prv=U, READ 0x8000_1000 size 3 -> resp_allow=1, resp_hit=1, resp_idx=0, resp_valid 2 cycles after accept.
REQ-036 Same entry, WRITE, W=0, prv=U -> resp_allow=0; prv=M, L=0 -> resp_allow=1; prv=M, L=1 -> resp_allow=0.
REQ-037 Entries 2 TOR [0x1000,0x2000) X=1, 5 NA4 0x1FFC R=1; EXEC 0x1FFC size 2 -> hit idx 2, allow=1, latency 4.
REQ-038 READ 0x1FFE size 2 against TOR [0x1000,0x2000) -> partial: resp_hit=1, resp_allow=0.
REQ-039 All entries OFF, prv=S -> resp_hit=0, allow=0 after N_PMP+1 cycles; prv=M -> allow=1.
REQ-040 csr_update at scan index 3 then flush during RESP with resp_ready=0 -> scan restarts at 0, flush yields IDLE, no resp_valid pulse, req_ready=1 next cycle.
